mac_host_driver: RTL

//  Host-side initiator for the MAC peripheral's 2-cycle byte protocol. Takes one MAC command
//  (A, B, clear_and_mult, signed) on a valid/ready port and serialises it as A+control, then B.

---
 rtl/mac_host_driver_pkg.sv | 25 ++
 rtl/mac_host_driver.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/mac_host_driver_pkg.sv
// Shared definitions for the MAC host driver: widths, FSM encodings and the latched command payload.
package mac_host_driver_pkg;

    localparam int unsigned BYTE_W       = 8;
    localparam int unsigned RES_W        = 16;
    localparam int unsigned STATE_W      = 3;
    localparam int unsigned RD_DELAY_DEF = 4;

    localparam logic [STATE_W-1:0] ST_IDLE    = 3'd0;
    localparam logic [STATE_W-1:0] ST_FLUSH   = 3'd1;
    localparam logic [STATE_W-1:0] ST_SEND_A  = 3'd2;
    localparam logic [STATE_W-1:0] ST_SEND_B  = 3'd3;
    localparam logic [STATE_W-1:0] ST_WAIT    = 3'd4;
    localparam logic [STATE_W-1:0] ST_READ_LO = 3'd5;
    localparam logic [STATE_W-1:0] ST_READ_HI = 3'd6;
    localparam logic [STATE_W-1:0] ST_RESP    = 3'd7;

    typedef struct packed {
        logic [BYTE_W-1:0] a;
        logic [BYTE_W-1:0] b;
        logic              clear_mult;
        logic              signed_mode;
    } cmd_t;

endpackage

// File: rtl/mac_host_driver.sv
// Host-side initiator for the MAC peripheral's 2-cycle byte protocol: sends A+ctl then B,
// waits RD_DELAY idle cycles, captures the 16-bit result a byte at a time and returns it.
module mac_host_driver
    import mac_host_driver_pkg::*;
#(
    parameter int unsigned RD_DELAY = RD_DELAY_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [BYTE_W-1:0] cmd_a,
    input  logic [BYTE_W-1:0] cmd_b,
    input  logic              cmd_clear_mult,
    input  logic              cmd_signed,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [RES_W-1:0]  rsp_result,
    output logic              rsp_overflow,
    output logic              bus_enable,
    output logic [BYTE_W-1:0] bus_data,
    output logic              bus_clear_and_mult,
    output logic              bus_signed_mode,
    input  logic [BYTE_W-1:0] bus_rdata,
    input  logic              bus_overflow,
    input  logic              bus_data_ready,
    input  logic              bus_frame_valid,
    output logic              frame_err
);

    localparam int unsigned CNT_W = $clog2(RD_DELAY + 1);

    logic [STATE_W-1:0] state, state_d;
    cmd_t               cmd_q, cmd_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               stall_q, stall_d;

    logic               cmd_ready_d;
    logic               rsp_valid_d;
    logic [RES_W-1:0]   rsp_result_d;
    logic               rsp_overflow_d;
    logic               bus_enable_d;
    logic [BYTE_W-1:0]  bus_data_d;
    logic               bus_clear_and_mult_d;
    logic               bus_signed_mode_d;
    logic               frame_err_d;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Datapath and output registers; outputs are decoded from the next state so they line up with it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_q              <= '0;
            cnt_q              <= '0;
            stall_q            <= 1'b0;
            cmd_ready          <= 1'b0;
            rsp_valid          <= 1'b0;
            rsp_result         <= '0;
            rsp_overflow       <= 1'b0;
            bus_enable         <= 1'b0;
            bus_data           <= '0;
            bus_clear_and_mult <= 1'b0;
            bus_signed_mode    <= 1'b0;
            frame_err          <= 1'b0;
        end else begin
            cmd_q              <= cmd_d;
            cnt_q              <= cnt_d;
            stall_q            <= stall_d;
            cmd_ready          <= cmd_ready_d;
            rsp_valid          <= rsp_valid_d;
            rsp_result         <= rsp_result_d;
            rsp_overflow       <= rsp_overflow_d;
            bus_enable         <= bus_enable_d;
            bus_data           <= bus_data_d;
            bus_clear_and_mult <= bus_clear_and_mult_d;
            bus_signed_mode    <= bus_signed_mode_d;
            frame_err          <= frame_err_d;
        end
    end

    // Next-state, datapath capture and registered-output decode
    always_comb begin
        state_d              = state;
        cmd_d                = cmd_q;
        cnt_d                = cnt_q;
        stall_d              = 1'b0;
        rsp_result_d         = rsp_result;
        rsp_overflow_d       = rsp_overflow;
        frame_err_d          = 1'b0;
        cmd_ready_d          = 1'b0;
        rsp_valid_d          = 1'b0;
        bus_enable_d         = 1'b0;
        bus_data_d           = '0;
        bus_clear_and_mult_d = 1'b0;
        bus_signed_mode_d    = 1'b0;

        case (state)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    cmd_d.a           = cmd_a;
                    cmd_d.b           = cmd_b;
                    cmd_d.clear_mult  = cmd_clear_mult;
                    cmd_d.signed_mode = cmd_signed;
                    state_d           = ST_SEND_A;
                end else if (!bus_data_ready) begin
                    // Second consecutive not-ready cycle: peripheral is stuck waiting for byte 2
                    if (stall_q) begin
                        state_d = ST_FLUSH;
                    end else begin
                        stall_d = 1'b1;
                    end
                end
            end
            ST_FLUSH:  state_d = ST_IDLE;
            ST_SEND_A: state_d = ST_SEND_B;
            ST_SEND_B: begin
                state_d = ST_WAIT;
                cnt_d   = CNT_W'(1);
            end
            ST_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if ((cnt_q == CNT_W'(1)) && !bus_frame_valid) begin
                    frame_err_d = 1'b1;
                end
                if (cnt_q == CNT_W'(RD_DELAY - 1)) begin
                    state_d = ST_READ_LO;
                end
            end
            ST_READ_LO: begin
                rsp_result_d[BYTE_W-1:0] = bus_rdata;
                rsp_overflow_d           = bus_overflow;
                state_d                  = ST_READ_HI;
            end
            ST_READ_HI: begin
                rsp_result_d[RES_W-1:BYTE_W] = bus_rdata;
                state_d                      = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        cmd_ready_d = (state_d == ST_IDLE) && bus_data_ready;
        rsp_valid_d = (state_d == ST_RESP);

        case (state_d)
            ST_FLUSH: begin
                bus_enable_d = 1'b1;
            end
            ST_SEND_A: begin
                bus_enable_d         = 1'b1;
                bus_data_d           = cmd_d.a;
                bus_clear_and_mult_d = cmd_d.clear_mult;
                bus_signed_mode_d    = cmd_d.signed_mode;
            end
            ST_SEND_B: begin
                bus_enable_d         = 1'b1;
                bus_data_d           = cmd_d.b;
                bus_clear_and_mult_d = cmd_d.clear_mult;
                bus_signed_mode_d    = cmd_d.signed_mode;
            end
            default: ;
        endcase
    end

endmodule
